// File: rtl/if_pkg.sv
// Shared types and default sizes for the instruction fetch unit.
// Contents: fetch FSM state enum, default address/data widths, reset PC, buffer depth.
// No logic; imported by the fetch unit, its FIFO and the bus interface.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  localparam int          IF_ADDR_W     = 32;
  localparam int          IF_DATA_W     = 32;
  localparam int          IF_FIFO_DEPTH = 4;
  localparam logic [31:0] IF_RESET_PC   = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
// imem_*: request/grant plus in-order response; instr_*: valid/ready hand-off to decode.
// master = fetch unit side, slave = memory/decode side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = if_pkg::IF_ADDR_W,
  parameter int DATA_W = if_pkg::IF_DATA_W
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous instruction buffer with single-cycle flush.
// Ports: clk/rst_n, flush_i, push_i/push_dat_i, pop_i, head_vld_o/head_dat_o, count_o.
// Latency: a push is visible at the head the next cycle; the caller never pushes when full.
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic                       head_vld_o,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_i && !flush_i) mem_q[wr_q] <= push_dat_i;
    end
  end

  assign head_vld_o = (cnt_q != '0);
  assign head_dat_o = mem_q[rd_q];
  assign count_o    = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word fetches, buffers responses for decode.
// Ports: clk, rst_n, fetch_en, redirect_valid/redirect_pc, bus (imem req/gnt/rvalid, instr valid/ready).
// Latency: response cycle N -> instr_valid cycle N+1; requests stop when buffer+in-flight reach FIFO_DEPTH.
// Optional: define FETCH_TRACE_EN for a simulation-only push/redirect trace.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter int                ADDR_W     = IF_ADDR_W,
  parameter int                DATA_W     = IF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(IF_RESET_PC),
  parameter int                FIFO_DEPTH = IF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  instr_fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;

  fetch_state_e             state_q, state_d;
  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic [ADDR_W-1:0]        resp_pc_q, resp_pc_d;
  cnt_t                     outst_q, outst_d;
  cnt_t                     drop_q, drop_d;
  cnt_t                     fifo_count, credits;
  logic                     has_credit, req, accept, resp, push, pop, fifo_vld;
  logic [DATA_W+ADDR_W-1:0] fifo_head;

  // Every in-flight request owns a buffer slot, so the FIFO can never overflow.
  assign credits    = cnt_t'(FIFO_DEPTH) - fifo_count - outst_q;
  assign has_credit = (credits != '0);

  assign req    = (state_q == FETCH) && has_credit && !redirect_valid;
  assign accept = req && bus.imem_gnt;
  assign resp   = bus.imem_rvalid;
  // Responses belonging to the pre-redirect stream are dropped, including one in the redirect cycle.
  assign push   = resp && !redirect_valid && (drop_q == '0);
  assign pop    = fifo_vld && bus.instr_ready && !redirect_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (fetch_en) state_d = FETCH;
      FETCH: begin
        if (!fetch_en)        state_d = IDLE;
        else if (!has_credit) state_d = STALL;
      end
      STALL: if (fetch_en && has_credit) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    drop_d    = drop_q;
    outst_d   = outst_q + cnt_t'(accept) - cnt_t'(resp);
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
      drop_d    = outst_q - cnt_t'(resp);
    end else begin
      if (accept) pc_d = pc_q + ADDR_W'(1);
      if (push) resp_pc_d = resp_pc_q + ADDR_W'(1);
      if (resp && (drop_q != '0)) drop_d = drop_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect_valid),
    .push_i     (push),
    .push_dat_i ({bus.imem_rdata, resp_pc_q}),
    .pop_i      (pop),
    .head_vld_o (fifo_vld),
    .head_dat_o (fifo_head),
    .count_o    (fifo_count)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = fifo_vld;
  // Head fields read as zero while the buffer is empty.
  assign bus.instr_data  = fifo_vld ? fifo_head[ADDR_W +: DATA_W] : '0;
  assign bus.instr_pc    = fifo_vld ? fifo_head[ADDR_W-1:0] : '0;

`ifdef FETCH_TRACE_EN
  always @(posedge clk) begin
    if (rst_n && push)           $display("fetch pc=%h instr=%h", resp_pc_q, bus.imem_rdata);
    if (rst_n && redirect_valid) $display("redirect pc=%h", redirect_pc);
  end
`else
`endif

endmodule
